// File: rtl/mult_pkg.sv
// Shared constants and the operand bundle type for the pipelined multiplier.
// Bundle fields are sized to the widest legal build; narrower builds zero-pad.
package mult_pkg;

  localparam int MULT_LATENCY = 3;
  localparam int WIDTH_MIN    = 4;
  localparam int WIDTH_MAX    = 16;
  localparam int TAG_W_MIN    = 1;
  localparam int TAG_W_MAX    = 8;

  typedef struct packed {
    logic [WIDTH_MAX-1:0] x;
    logic [WIDTH_MAX-1:0] y;
    logic                 is_signed;
    logic [TAG_W_MAX-1:0] tag;
  } op_bundle_t;

endpackage

// File: rtl/csa.sv
// W-bit 3:2 carry-save adder; carry_o is unshifted.
module csa #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  for (genvar k = 0; k < W; k++) begin : g_fa
    full_adder u_fa (
      .a_i   (a_i[k]),
      .b_i   (b_i[k]),
      .cin_i (c_i[k]),
      .sum_o (sum_o[k]),
      .cout_o(carry_o[k])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/rca.sv
// W-bit ripple-carry adder.
module rca #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] c;

  assign c[0]   = cin_i;
  assign cout_o = c[W];

  for (genvar k = 0; k < W; k++) begin : g_fa
    full_adder u_fa (
      .a_i   (a_i[k]),
      .b_i   (b_i[k]),
      .cin_i (c[k]),
      .sum_o (sum_o[k]),
      .cout_o(c[k+1])
    );
  end

endmodule

// File: rtl/wallace_reduce.sv
// Combinational reduction of N vectors of 2W bits down to sum + carry.
// carry_o is unshifted; the caller adds sum_o + (carry_o << 1).
module wallace_reduce #(
  parameter int W = 8,
  parameter int N = 2 * W
) (
  input  logic [N-1:0][2*W-1:0] ops_i,
  output logic [2*W-1:0]        sum_o,
  output logic [2*W-1:0]        carry_o
);

  localparam int PW = 2 * W;
  localparam int NV = 3 * N - 5;

  // Vectors are consumed in FIFO order, so each CSA level finishes before
  // the next starts and the depth stays logarithmic in N.
  logic [PW-1:0] v  [NV];
  logic [PW-1:0] cs [N-2];

  for (genvar i = 0; i < N; i++) begin : g_in
    assign v[i] = ops_i[i];
  end

  for (genvar j = 0; j < N - 2; j++) begin : g_csa
    csa #(.W(PW)) u_csa (
      .a_i    (v[3*j]),
      .b_i    (v[3*j+1]),
      .c_i    (v[3*j+2]),
      .sum_o  (v[N+2*j]),
      .carry_o(cs[j])
    );
    if (j < N - 3) begin : g_sh
      assign v[N+2*j+1] = cs[j] << 1;
    end
  end

  assign sum_o   = v[NV-1];
  assign carry_o = cs[N-3];

endmodule

// File: rtl/pipelined_wallace_mult.sv
// 3-stage valid/ready Wallace multiplier, signed or unsigned per bundle.
module pipelined_wallace_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      TAG_W < TAG_W_MIN || TAG_W > TAG_W_MAX) begin : g_bad_cfg
    $error("pipelined_wallace_mult: illegal WIDTH/TAG_W");
  end

  op_bundle_t r0_q, r0_d;
  logic v0_q, v1_q, v2_q;
  logic ld0, ld1, ld2;

  logic [PW-1:0]    sum1_q, carry1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [PW-1:0]    prod2_q;
  logic [TAG_W-1:0] tag2_q;

  // A stage loads when empty or when its successor moves this cycle.
  assign ld2      = !v2_q || out_ready;
  assign ld1      = !v1_q || ld2;
  assign ld0      = !v0_q || ld1;
  assign in_ready = ld0 && !reset;

  always_comb begin
    r0_d           = '0;
    r0_d.x         = WIDTH_MAX'(in_x);
    r0_d.y         = WIDTH_MAX'(in_y);
    r0_d.is_signed = in_signed;
    r0_d.tag       = TAG_W_MAX'(in_tag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q <= 1'b0;
      r0_q <= '0;
    end else if (ld0) begin
      v0_q <= in_valid;
      if (in_valid) r0_q <= r0_d;
    end
  end

  logic [WIDTH-1:0]        x0, y0;
  logic [PW-1:0]           ext_x, ext_y;
  logic [PW-1:0][PW-1:0]   pp;
  logic [PW-1:0]           sum_d, carry_d;
  logic                    unused_r0;

  assign x0        = r0_q.x[WIDTH-1:0];
  assign y0        = r0_q.y[WIDTH-1:0];
  assign ext_x     = {{WIDTH{r0_q.is_signed & x0[WIDTH-1]}}, x0};
  assign ext_y     = {{WIDTH{r0_q.is_signed & y0[WIDTH-1]}}, y0};
  assign unused_r0 = ^r0_q;

  always_comb begin
    pp = '0;
    for (int i = 0; i < PW; i++) begin
      pp[i] = (ext_x & {PW{ext_y[i]}}) << i;
    end
  end

  wallace_reduce #(.W(WIDTH), .N(PW)) u_reduce (
    .ops_i  (pp),
    .sum_o  (sum_d),
    .carry_o(carry_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      sum1_q   <= '0;
      carry1_q <= '0;
      tag1_q   <= '0;
    end else if (ld1) begin
      v1_q <= v0_q;
      if (v0_q) begin
        sum1_q   <= sum_d;
        carry1_q <= carry_d;
        tag1_q   <= r0_q.tag[TAG_W-1:0];
      end
    end
  end

  logic [PW-1:0] carry_sh, prod_d;
  logic          unused_cout;

  assign carry_sh = carry1_q << 1;

  rca #(.W(PW)) u_rca (
    .a_i   (sum1_q),
    .b_i   (carry_sh),
    .cin_i (1'b0),
    .sum_o (prod_d),
    .cout_o(unused_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q    <= 1'b0;
      prod2_q <= '0;
      tag2_q  <= '0;
    end else if (ld2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        prod2_q <= prod_d;
        tag2_q  <= tag1_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_prod  = prod2_q;
  assign out_tag   = tag2_q;

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// Scoreboard bench for pipelined_wallace_mult at WIDTH 8, 4 and 16.
module tb_pipelined_wallace_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_x, in_y;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_prod;

  logic        in_valid4, in_ready4, in_signed4, out_valid4, out_ready4;
  logic [3:0]  in_x4, in_y4;
  logic [0:0]  in_tag4, out_tag4;
  logic [7:0]  out_prod4;

  logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
  logic [15:0] in_x16, in_y16;
  logic [7:0]  in_tag16, out_tag16;
  logic [31:0] out_prod16;

  pipelined_wallace_mult #(.WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  pipelined_wallace_mult #(.WIDTH(4), .TAG_W(1)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_x(in_x4), .in_y(in_y4), .in_signed(in_signed4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_prod(out_prod4), .out_tag(out_tag4)
  );

  pipelined_wallace_mult #(.WIDTH(16), .TAG_W(8)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_x(in_x16), .in_y(in_y16), .in_signed(in_signed16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_prod(out_prod16), .out_tag(out_tag16)
  );

  typedef struct {
    bit          ok;
    logic [31:0] prod;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  exp_t q16[$];
  int total  = 0;
  int passed = 0;

  function automatic logic [31:0] ref_mul(int w, logic [15:0] x,
                                          logic [15:0] y, bit s);
    longint xv, yv, p, m;
    xv = longint'(x);
    yv = longint'(y);
    if (s && x[w-1]) xv -= longint'(1) << w;
    if (s && y[w-1]) yv -= longint'(1) << w;
    p = xv * yv;
    m = (longint'(1) << (2 * w)) - 1;
    return 32'(p & m);
  endfunction

  // One clock of the WIDTH=8 scoreboard: sample transfers at negedge.
  task automatic step(output bit acc, output bit drn, output exp_t e,
                      output logic [15:0] ap, output logic [3:0] at);
    @(negedge clk);
    drn    = out_valid && out_ready;
    acc    = in_valid && in_ready;
    ap     = out_prod;
    at     = out_tag;
    e.ok   = 1'b0;
    e.prod = '0;
    e.tag  = '0;
    if (drn && q.size() > 0) e = q.pop_front();
    if (acc)
      q.push_back('{ok: 1'b1,
                    prod: ref_mul(8, {8'h0, in_x}, {8'h0, in_y}, in_signed),
                    tag: {4'h0, in_tag}});
    @(posedge clk);
    #1;
  endtask

  task automatic new_bundle();
    in_x      = 8'($urandom);
    in_y      = 8'($urandom);
    in_signed = 1'($urandom);
    in_tag    = 4'($urandom);
  endtask

  task automatic test_reset();
    int late;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_x      = 8'h12;
    in_y      = 8'h34;
    in_signed = 1'b0;
    in_tag    = 4'h9;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid === 1'b0 && out_prod === 16'h0 && out_tag === 4'h0)
      passed++;
    else
      $display("FAIL reset_state: valid=%b prod=%h tag=%h, want 0/0000/0",
               out_valid, out_prod, out_tag);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready === 1'b1) passed++;
    else $display("FAIL reset_in_ready: got %b want 1", in_ready);
    late = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) late++;
    end
    @(posedge clk);
    #1;
    total++;
    if (late == 0) passed++;
    else $display("FAIL reset_no_accept: %0d valid cycles, want 0", late);
  endtask

  task automatic test_unsigned();
    out_ready = 1'b1;
    in_x      = 8'd255;
    in_y      = 8'd255;
    in_signed = 1'b0;
    in_tag    = 4'd3;
    in_valid  = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready === 1'b1) passed++;
    else $display("FAIL unsigned_ready: got %b want 1", in_ready);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid === 1'b0) passed++;
    else $display("FAIL unsigned_early: out_valid=%b want 0", out_valid);
    @(posedge clk);
    #1;
    total++;
    if (out_valid === 1'b1 && out_prod === 16'hFE01 && out_tag === 4'd3)
      passed++;
    else
      $display("FAIL unsigned_result: valid=%b prod=%h tag=%h want 1/fe01/3",
               out_valid, out_prod, out_tag);
    @(posedge clk);
    #1;
    total++;
    if (out_valid === 1'b0) passed++;
    else $display("FAIL unsigned_drain: out_valid=%b want 0", out_valid);
  endtask

  task automatic test_signed();
    logic [7:0]  xs [3];
    logic [7:0]  ys [3];
    logic [15:0] ps [3];
    xs = '{8'h80, 8'hFF, 8'h7F};
    ys = '{8'h80, 8'h05, 8'h81};
    ps = '{16'h4000, 16'hFFFB, 16'hC0FF};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_x      = xs[i];
      in_y      = ys[i];
      in_signed = 1'b1;
      in_tag    = 4'(i + 5);
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      total++;
      if (out_valid === 1'b1 && out_prod === ps[i] &&
          out_tag === 4'(i + 5))
        passed++;
      else
        $display("FAIL signed_%0d: valid=%b prod=%h tag=%h want 1/%h/%h",
                 i, out_valid, out_prod, out_tag, ps[i], 4'(i + 5));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stream();
    bit          acc, drn, started;
    exp_t        e;
    logic [15:0] ap;
    logic [3:0]  at;
    int sent, got, gaps, stalls;
    sent = 0; got = 0; gaps = 0; stalls = 0; started = 1'b0;
    out_ready = 1'b1;
    new_bundle();
    in_valid = 1'b1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      step(acc, drn, e, ap, at);
      if (sent < 100 && !acc) stalls++;
      if (acc) begin
        sent++;
        if (sent < 100) new_bundle();
        else in_valid = 1'b0;
      end
      if (drn) begin
        started = 1'b1;
        got++;
        total++;
        if (e.ok && ap === e.prod[15:0] && at === e.tag[3:0]) passed++;
        else
          $display("FAIL stream_%0d: prod=%h tag=%h want %h/%h ok=%0d",
                   got, ap, at, e.prod[15:0], e.tag[3:0], e.ok);
      end else if (started && got < 100) begin
        gaps++;
      end
    end
    total++;
    if (got == 100 && gaps == 0 && stalls == 0 && q.size() == 0) passed++;
    else
      $display("FAIL stream_rate: got=%0d gaps=%0d stalls=%0d left=%0d",
               got, gaps, stalls, q.size());
  endtask

  task automatic test_backpressure();
    bit          acc, drn;
    exp_t        e;
    logic [15:0] ap, hold, first;
    logic [3:0]  at;
    int k, got, moved;
    k = 0; got = 0; moved = 0; hold = '0;
    out_ready = 1'b0;
    new_bundle();
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(acc, drn, e, ap, at);
      if (acc) begin
        k++;
        new_bundle();
      end
      if (c == 2) hold = out_prod;
      if (c > 2 && out_prod !== hold) moved++;
    end
    first = q.size() > 0 ? q[0].prod[15:0] : 16'hxxxx;
    total++;
    if (k == 3 && in_ready === 1'b0 && out_valid === 1'b1) passed++;
    else
      $display("FAIL bp_fill: accepted=%0d in_ready=%b out_valid=%b want 3/0/1",
               k, in_ready, out_valid);
    total++;
    if (moved == 0 && out_prod === first) passed++;
    else
      $display("FAIL bp_hold: prod=%h moved=%0d want %h stable",
               out_prod, moved, first);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      step(acc, drn, e, ap, at);
      if (acc) begin
        k++;
        if (k < 5) new_bundle();
        else in_valid = 1'b0;
      end
      if (drn) begin
        got++;
        total++;
        if (e.ok && ap === e.prod[15:0] && at === e.tag[3:0]) passed++;
        else
          $display("FAIL bp_out_%0d: prod=%h tag=%h want %h/%h ok=%0d",
                   got, ap, at, e.prod[15:0], e.tag[3:0], e.ok);
      end
    end
    total++;
    if (got == 5 && k == 5 && q.size() == 0 && out_valid === 1'b0) passed++;
    else
      $display("FAIL bp_count: got=%0d accepted=%0d left=%0d want 5/5/0",
               got, k, q.size());
  endtask

  task automatic test_reset_mid();
    bit          acc, drn;
    exp_t        e;
    logic [15:0] ap, want;
    logic [3:0]  at;
    int stale;
    out_ready = 1'b1;
    new_bundle();
    in_valid = 1'b1;
    step(acc, drn, e, ap, at);
    new_bundle();
    step(acc, drn, e, ap, at);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    total++;
    if (out_valid === 1'b0) passed++;
    else $display("FAIL rmid_valid: out_valid=%b want 0", out_valid);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    @(posedge clk);
    #1;
    total++;
    if (stale == 0) passed++;
    else $display("FAIL rmid_stale: %0d stale cycles want 0", stale);
    in_x      = 8'h9C;
    in_y      = 8'h0B;
    in_signed = 1'b1;
    in_tag    = 4'hA;
    want      = ref_mul(8, 16'h009C, 16'h000B, 1'b1);
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid === 1'b0) passed++;
    else $display("FAIL rmid_early: out_valid=%b want 0", out_valid);
    @(posedge clk);
    #1;
    total++;
    if (out_valid === 1'b1 && out_prod === want && out_tag === 4'hA) passed++;
    else
      $display("FAIL rmid_fresh: valid=%b prod=%h tag=%h want 1/%h/a",
               out_valid, out_prod, out_tag, want);
    @(posedge clk);
    #1;
  endtask

  task automatic test_widths();
    exp_t       e;
    bit         acc;
    logic [8:0] iv;
    int idx, got;
    idx = 0; got = 0;
    out_ready4 = 1'b1;
    iv = '0;
    in_x4 = iv[3:0]; in_y4 = iv[7:4]; in_signed4 = iv[8]; in_tag4 = iv[0:0];
    in_valid4 = 1'b1;
    for (int c = 0; c < 2000 && got < 512; c++) begin
      @(negedge clk);
      acc = in_valid4 && in_ready4;
      if (out_valid4 && out_ready4) begin
        e.ok = 1'b0; e.prod = '0; e.tag = '0;
        if (q4.size() > 0) e = q4.pop_front();
        got++;
        total++;
        if (e.ok && out_prod4 === e.prod[7:0] && out_tag4 === e.tag[0:0])
          passed++;
        else
          $display("FAIL w4_%0d: prod=%h tag=%b want %h/%b ok=%0d",
                   got, out_prod4, out_tag4, e.prod[7:0], e.tag[0], e.ok);
      end
      if (acc)
        q4.push_back('{ok: 1'b1,
                       prod: ref_mul(4, {12'h0, in_x4}, {12'h0, in_y4},
                                     in_signed4),
                       tag: {7'h0, in_tag4}});
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        iv = 9'(idx);
        in_x4 = iv[3:0]; in_y4 = iv[7:4]; in_signed4 = iv[8];
        in_tag4 = iv[0:0];
        if (idx >= 512) in_valid4 = 1'b0;
      end
    end
    total++;
    if (got == 512 && q4.size() == 0) passed++;
    else $display("FAIL w4_count: got=%0d left=%0d want 512/0", got, q4.size());

    idx = 0; got = 0;
    out_ready16 = 1'b1;
    in_x16 = 16'h8000; in_y16 = 16'h8000; in_signed16 = 1'b1; in_tag16 = 8'h00;
    in_valid16 = 1'b1;
    for (int c = 0; c < 1000 && got < 300; c++) begin
      @(negedge clk);
      acc = in_valid16 && in_ready16;
      if (out_valid16 && out_ready16) begin
        e.ok = 1'b0; e.prod = '0; e.tag = '0;
        if (q16.size() > 0) e = q16.pop_front();
        got++;
        total++;
        if (e.ok && out_prod16 === e.prod && out_tag16 === e.tag) passed++;
        else
          $display("FAIL w16_%0d: prod=%h tag=%h want %h/%h ok=%0d",
                   got, out_prod16, out_tag16, e.prod, e.tag, e.ok);
      end
      if (acc)
        q16.push_back('{ok: 1'b1,
                        prod: ref_mul(16, in_x16, in_y16, in_signed16),
                        tag: in_tag16});
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == 1) begin
          in_x16 = 16'hFFFF; in_y16 = 16'hFFFF; in_signed16 = 1'b0;
        end else begin
          in_x16 = 16'($urandom); in_y16 = 16'($urandom);
          in_signed16 = 1'($urandom);
        end
        in_tag16 = 8'(idx);
        if (idx >= 300) in_valid16 = 1'b0;
      end
    end
    total++;
    if (got == 300 && q16.size() == 0) passed++;
    else $display("FAIL w16_count: got=%0d left=%0d want 300/0", got, q16.size());
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0; in_tag = '0;
    out_ready   = 1'b1;
    in_valid4   = 1'b0; in_x4 = '0; in_y4 = '0; in_signed4 = 1'b0;
    in_tag4     = '0;   out_ready4 = 1'b1;
    in_valid16  = 1'b0; in_x16 = '0; in_y16 = '0; in_signed16 = 1'b0;
    in_tag16    = '0;   out_ready16 = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_widths();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
